ddr_req_arbiter: RTL and testbench
==================================

DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly:
- NUM_RD, 3, read clients (2..8).
- ADDR_W, 25, DDR address width.
- DATA_W, 128, DDR data width.
- CMD_DEPTH, 16, command FIFO entries (power of 2).
- TAG_DEPTH, 16, outstanding-read tag FIFO entries (power of 2).
REQ-002 Ports (name, direction, width, meaning) SHALL be exactly:
- clk_133M, in, 1, sole clock.
- rst_133M, in, 1, asynchronous active-high reset.
- init_done, in, 1, DDR controller ready.
- cmd_busy, in, 1, DDR controller cannot accept a command.
- wr_req, in, 1, write request; held until wr_ack.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, DATA_W, write data.
- wr_ack, out, 1, write accepted this cycle.
- rd_req, in, NUM_RD, per-client read request; held until ack.
- rd_addr, in, NUM_RD*ADDR_W, client i in bits [i*ADDR_W +: ADDR_W].
- rd_ack, out, NUM_RD, read accepted this cycle (one-hot or zero).
- ddr_data_valid, in, 1, read data beat from DDR.
- ddr_rd_data, in, DATA_W, read data.
- rd_data, out, DATA_W, registered read data, shared by all clients.
- rd_data_valid, out, NUM_RD, one-hot strobe to the owning client.
- cmd, out, 4, 4'b0100 write, 4'b0011 read.
- cmd_valid, out, 1, command strobe.
- ddr_address, out, ADDR_W; ddr_wr_data, out, DATA_W.
- busy, out, 1, command FIFO count >= CMD_DEPTH-2.
- tag_err, out, 1, sticky: data beat arrived with no outstanding tag.

Function
REQ-003 Request acceptance SHALL occur only when init_done=1, the command FIFO is not full, and (for reads) the tag FIFO is not full; at most one acceptance per cycle.
REQ-004 A pending write SHALL be accepted before any read.
REQ-005 Read selection SHALL follow the Configuration section.
REQ-006 An acceptance SHALL register the ack high for exactly one cycle, in the cycle after the request is sampled.
REQ-007 In the following cycle the accepted command SHALL be pushed into the command FIFO; a held request SHALL NOT be re-accepted while its ack is high.
REQ-008 A read acceptance SHALL push the client index into the tag FIFO in the same cycle as the command push.
REQ-009 Issue condition: init_done & ~cmd_busy & ~cmd_valid & command FIFO non-empty & no pop in the previous cycle. When met, the FIFO head SHALL be popped and cmd, ddr_address, ddr_wr_data and cmd_valid driven on the next cycle.
REQ-010 cmd_valid SHALL be high for exactly one cycle; issue spacing SHALL be at least 2 cycles.
REQ-011 Read commands SHALL drive ddr_wr_data = 0.
REQ-012 On ddr_data_valid with the tag FIFO non-empty: pop the tag; one cycle later drive rd_data = ddr_rd_data with rd_data_valid[tag] high for one cycle.
REQ-013 On ddr_data_valid with the tag FIFO empty: drop the beat and set tag_err until reset.
REQ-014 Data beats SHALL be returned strictly in issue order; push and pop in the same cycle SHALL leave the count unchanged.
REQ-015 While init_done=0: no acceptance and no issue; queued entries SHALL be retained.

Reset
REQ-016 rst_133M SHALL asynchronously clear both FIFOs, the round-robin pointer and tag_err.
REQ-017 Reset SHALL drive all outputs low, except busy, which SHALL reflect the empty FIFO (0).
REQ-018 Commands in flight at reset SHALL be discarded; their later data beats SHALL set tag_err.

Configuration
REQ-019 With RR_ARB_EN defined: reads SHALL be granted round-robin; the search starts at (last granted index + 1) mod NUM_RD, with the pointer at 0 after reset.
REQ-020 Without RR_ARB_EN: reads SHALL be granted by fixed priority, lowest index first; the pointer logic is absent.

Verification
REQ-021 wr_req and rd_req[1] both high at the same edge -> wr_ack first; rd_ack[1] 2 cycles later; cmd order 0100 then 0011.
REQ-022 RR_ARB_EN defined, rd_req=3'b111 held -> grants 0,1,2,0; undefined -> grants 0,0,0 while rd_req[0] remains high.
REQ-023 Reads from clients 2,0,1, then three ddr_data_valid beats A,B,C -> rd_data_valid 3'b100/A, 3'b001/B, 3'b010/C, each one cycle after its beat.
REQ-024 cmd_busy=1 with 16 reads queued -> busy=1, no further ack, cmd_valid=0; release cmd_busy -> cmd_valid every 2 cycles until empty.
REQ-025 ddr_data_valid with no outstanding reads -> tag_err=1 and stays 1; rst_133M pulse -> tag_err=0.
REQ-026 Assert rst_133M mid-stream with 5 commands queued -> cmd_valid=0 immediately, FIFOs empty, first post-reset request accepted normally.

Source files
------------

// File: rtl/ddr_req_arbiter.sv
// Arbitrates one write client and NUM_RD read clients onto a single DDR command port.
// Optional macro RR_ARB_EN selects round-robin read arbitration (default: fixed priority).
module ddr_req_arbiter #(
  parameter int NUM_RD    = 3,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 128,
  parameter int CMD_DEPTH = 16,
  parameter int TAG_DEPTH = 16
) (
  input  logic                     clk_133M,
  input  logic                     rst_133M,
  input  logic                     init_done,
  input  logic                     cmd_busy,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_ack,
  input  logic                     ddr_data_valid,
  input  logic [DATA_W-1:0]        ddr_rd_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [NUM_RD-1:0]        rd_data_valid,
  output logic [3:0]               cmd,
  output logic                     cmd_valid,
  output logic [ADDR_W-1:0]        ddr_address,
  output logic [DATA_W-1:0]        ddr_wr_data,
  output logic                     busy,
  output logic                     tag_err
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam int IW  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic              cmd_wr_mem   [CMD_DEPTH];
  logic [ADDR_W-1:0] cmd_addr_mem [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_data_mem [CMD_DEPTH];
  logic [CAW-1:0]    cmd_wr_ptr, cmd_rd_ptr;
  logic [CAW:0]      cmd_count;

  logic [IW-1:0]     tag_mem [TAG_DEPTH];
  logic [TAW-1:0]    tag_wr_ptr, tag_rd_ptr;
  logic [TAW:0]      tag_count;

  logic              acc_is_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic [IW-1:0]     acc_idx;
  logic              popped_q;

  logic              any_ack, can_acc, acc_wr, acc_rd;
  logic              cmd_full, cmd_empty, tag_full, tag_empty;
  logic              cmd_push, tag_push, issue, tag_pop;
  logic              rd_found;
  logic [IW-1:0]     rd_sel;
  logic [ADDR_W-1:0] sel_addr;

  assign cmd_full  = (cmd_count == (CAW+1)'(CMD_DEPTH));
  assign cmd_empty = (cmd_count == '0);
  assign tag_full  = (tag_count == (TAW+1)'(TAG_DEPTH));
  assign tag_empty = (tag_count == '0);
  assign busy      = (cmd_count >= (CAW+1)'(CMD_DEPTH-2));

  // A raised ack blocks any new acceptance, so the accepted entry is always
  // pushed before fullness is evaluated again.
  assign any_ack  = wr_ack | (|rd_ack);
  assign can_acc  = init_done & ~cmd_full & ~any_ack;
  assign acc_wr   = can_acc & wr_req;
  assign acc_rd   = can_acc & ~wr_req & ~tag_full & rd_found;
  assign cmd_push = any_ack;
  assign tag_push = |rd_ack;
  assign issue    = init_done & ~cmd_busy & ~cmd_valid & ~cmd_empty & ~popped_q;
  assign tag_pop  = ddr_data_valid & ~tag_empty;

`ifdef RR_ARB_EN
  logic [IW-1:0] rr_ptr;

  always_comb begin
    rd_found = 1'b0;
    rd_sel   = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (!rd_found && rd_req[i] && i >= 32'(rr_ptr)) begin
        rd_found = 1'b1;
        rd_sel   = IW'(i);
      end
    end
    // Wrap-around pass covers the clients below the pointer.
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (!rd_found && rd_req[i]) begin
        rd_found = 1'b1;
        rd_sel   = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M)
      rr_ptr <= '0;
    else if (acc_rd)
      rr_ptr <= (rd_sel == IW'(NUM_RD-1)) ? '0 : rd_sel + IW'(1);
  end
`else
  always_comb begin
    rd_found = 1'b0;
    rd_sel   = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (!rd_found && rd_req[i]) begin
        rd_found = 1'b1;
        rd_sel   = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_RD; i++)
      if (rd_sel == IW'(i)) sel_addr = rd_addr[i*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk_133M) begin
    if (cmd_push) begin
      cmd_wr_mem[cmd_wr_ptr]   <= acc_is_wr;
      cmd_addr_mem[cmd_wr_ptr] <= acc_addr;
      cmd_data_mem[cmd_wr_ptr] <= acc_data;
    end
    if (tag_push)
      tag_mem[tag_wr_ptr] <= acc_idx;
  end

  always_ff @(posedge clk_133M or posedge rst_133M) begin
    if (rst_133M) begin
      wr_ack        <= 1'b0;
      rd_ack        <= '0;
      acc_is_wr     <= 1'b0;
      acc_addr      <= '0;
      acc_data      <= '0;
      acc_idx       <= '0;
      cmd_wr_ptr    <= '0;
      cmd_rd_ptr    <= '0;
      cmd_count     <= '0;
      tag_wr_ptr    <= '0;
      tag_rd_ptr    <= '0;
      tag_count     <= '0;
      popped_q      <= 1'b0;
      cmd           <= '0;
      cmd_valid     <= 1'b0;
      ddr_address   <= '0;
      ddr_wr_data   <= '0;
      rd_data       <= '0;
      rd_data_valid <= '0;
      tag_err       <= 1'b0;
    end else begin
      wr_ack <= acc_wr;
      rd_ack <= acc_rd ? (NUM_RD'(1) << rd_sel) : '0;
      if (acc_wr) begin
        acc_is_wr <= 1'b1;
        acc_addr  <= wr_addr;
        acc_data  <= wr_data;
      end else if (acc_rd) begin
        acc_is_wr <= 1'b0;
        acc_addr  <= sel_addr;
        acc_data  <= '0;
        acc_idx   <= rd_sel;
      end

      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (issue)    cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      case ({cmd_push, issue})
        2'b10:   cmd_count <= cmd_count + (CAW+1)'(1);
        2'b01:   cmd_count <= cmd_count - (CAW+1)'(1);
        default: cmd_count <= cmd_count;
      endcase

      if (tag_push) tag_wr_ptr <= tag_wr_ptr + TAW'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + TAW'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_count <= tag_count + (TAW+1)'(1);
        2'b01:   tag_count <= tag_count - (TAW+1)'(1);
        default: tag_count <= tag_count;
      endcase

      popped_q  <= issue;
      cmd_valid <= issue;
      if (issue) begin
        cmd         <= cmd_wr_mem[cmd_rd_ptr] ? 4'b0100 : 4'b0011;
        ddr_address <= cmd_addr_mem[cmd_rd_ptr];
        ddr_wr_data <= cmd_wr_mem[cmd_rd_ptr] ? cmd_data_mem[cmd_rd_ptr] : '0;
      end

      rd_data_valid <= tag_pop ? (NUM_RD'(1) << tag_mem[tag_rd_ptr]) : '0;
      if (tag_pop) rd_data <= ddr_rd_data;
      if (ddr_data_valid && tag_empty) tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter with default parameters; follows RR_ARB_EN if defined.
module tb_ddr_req_arbiter;

  localparam int NUM_RD = 3;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 128;

  logic                     clk_133M = 1'b0;
  logic                     rst_133M;
  logic                     init_done;
  logic                     cmd_busy;
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ack;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_ack;
  logic                     ddr_data_valid;
  logic [DATA_W-1:0]        ddr_rd_data;
  logic [DATA_W-1:0]        rd_data;
  logic [NUM_RD-1:0]        rd_data_valid;
  logic [3:0]               cmd;
  logic                     cmd_valid;
  logic [ADDR_W-1:0]        ddr_address;
  logic [DATA_W-1:0]        ddr_wr_data;
  logic                     busy;
  logic                     tag_err;

  int checks = 0;
  int errors = 0;
  int n_ack, n_cv;

  ddr_req_arbiter #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .CMD_DEPTH(16), .TAG_DEPTH(16)) dut (
    .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done),
    .cmd_busy(cmd_busy), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .cmd(cmd), .cmd_valid(cmd_valid),
    .ddr_address(ddr_address), .ddr_wr_data(ddr_wr_data), .busy(busy), .tag_err(tag_err)
  );

  always #4 clk_133M = ~clk_133M;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_133M);
    #1;
  endtask

  task automatic clear_inputs();
    wr_req = 1'b0; rd_req = '0; ddr_data_valid = 1'b0; cmd_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_133M = 1'b1;
    step();
    rst_133M = 1'b0;
  endtask

  initial begin
    rst_133M = 1'b1; init_done = 1'b0; cmd_busy = 1'b0; wr_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
    ddr_data_valid = 1'b0; ddr_rd_data = '0;
    rd_addr[0*ADDR_W +: ADDR_W] = 25'h0000A00;
    rd_addr[1*ADDR_W +: ADDR_W] = 25'h0000B11;
    rd_addr[2*ADDR_W +: ADDR_W] = 25'h0000C22;
    step(); step();

    // Reset state
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_rd_dv", rd_data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);
    rst_133M = 1'b0;

    // No acceptance while init_done is low
    wr_req = 1'b1; wr_addr = 25'h1ABCDE; wr_data = 128'hDEAD_BEEF_0000_1111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("noinit_wr_ack", wr_ack, 0);
      chk("noinit_cmd_valid", cmd_valid, 0);
    end
    wr_req = 1'b0;

    // Write beats simultaneous read; write command first
    init_done = 1'b1;
    wr_req = 1'b1; rd_req = 3'b010;
    step();
    chk("wr_first_ack", wr_ack, 1);
    chk("wr_first_rd_ack", rd_ack, 0);
    wr_req = 1'b0;
    step();
    chk("gap_wr_ack", wr_ack, 0);
    chk("gap_rd_ack", rd_ack, 0);
    step();
    chk("rd1_ack", rd_ack, 3'b010);
    chk("wr_cmd_valid", cmd_valid, 1);
    chk("wr_cmd", cmd, 4'b0100);
    chk("wr_cmd_addr", ddr_address, 25'h1ABCDE);
    chk("wr_cmd_data", ddr_wr_data, 128'hDEAD_BEEF_0000_1111);
    rd_req = '0;
    step();
    chk("cv_one_cycle", cmd_valid, 0);
    chk("rd1_ack_drop", rd_ack, 0);
    step();
    chk("rd_cmd_valid", cmd_valid, 1);
    chk("rd_cmd", cmd, 4'b0011);
    chk("rd_cmd_addr", ddr_address, 25'h0000B11);
    chk("rd_cmd_wdata0", ddr_wr_data, 0);
    ddr_data_valid = 1'b1; ddr_rd_data = 128'h5555;
    step();
    ddr_data_valid = 1'b0;
    chk("beat1_dv", rd_data_valid, 3'b010);
    chk("beat1_data", rd_data, 128'h5555);
    step();
    chk("beat1_dv_drop", rd_data_valid, 0);
    chk("beat1_tag_err", tag_err, 0);

    // Read arbitration with all clients held
    do_reset();
    cmd_busy = 1'b1; rd_req = 3'b111;
    for (int g = 0; g < 4; g++) begin
`ifdef RR_ARB_EN
      logic [NUM_RD-1:0] exp_g;
      exp_g = (g == 0 || g == 3) ? 3'b001 : ((g == 1) ? 3'b010 : 3'b100);
      step();
      chk("arb_grant", rd_ack, exp_g);
`else
      step();
      chk("arb_grant", rd_ack, 3'b001);
`endif
      step();
      chk("arb_gap", rd_ack, 0);
    end

    // Return order follows issue order: clients 2,0,1
    do_reset();
    rd_req = 3'b100; step(); chk("ord_ack2", rd_ack, 3'b100); rd_req = '0; step();
    rd_req = 3'b001; step(); chk("ord_ack0", rd_ack, 3'b001); rd_req = '0; step();
    rd_req = 3'b010; step(); chk("ord_ack1", rd_ack, 3'b010); rd_req = '0; step();
    ddr_data_valid = 1'b1; ddr_rd_data = 128'hAAAA;
    step(); chk("ord_dv_A", rd_data_valid, 3'b100); chk("ord_data_A", rd_data, 128'hAAAA);
    ddr_rd_data = 128'hBBBB;
    step(); chk("ord_dv_B", rd_data_valid, 3'b001); chk("ord_data_B", rd_data, 128'hBBBB);
    ddr_rd_data = 128'hCCCC;
    step(); chk("ord_dv_C", rd_data_valid, 3'b010); chk("ord_data_C", rd_data, 128'hCCCC);
    ddr_data_valid = 1'b0;
    step(); chk("ord_dv_end", rd_data_valid, 0); chk("ord_tag_err", tag_err, 0);

    // Fill while cmd_busy, then drain
    do_reset();
    cmd_busy = 1'b1; rd_req = 3'b001;
    n_ack = 0; n_cv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rd_ack != 0) n_ack++;
      if (cmd_valid) n_cv++;
    end
    chk("fill_acks", n_ack, 16);
    chk("fill_no_cv", n_cv, 0);
    chk("fill_busy", busy, 1);
    rd_req = '0; cmd_busy = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      step();
      chk("drain_cv", cmd_valid, ((k % 2) == 1 && k <= 31) ? 1 : 0);
    end
    chk("drain_busy", busy, 0);

    // Orphan data beat sets sticky tag_err
    do_reset();
    ddr_data_valid = 1'b1; ddr_rd_data = 128'h7777;
    step();
    ddr_data_valid = 1'b0;
    chk("orphan_dv", rd_data_valid, 0);
    chk("orphan_tag_err", tag_err, 1);
    step(); step();
    chk("orphan_sticky", tag_err, 1);
    do_reset();
    chk("orphan_cleared", tag_err, 0);

    // Reset mid-stream with queued commands
    cmd_busy = 1'b1; wr_req = 1'b1; wr_addr = 25'h0123; wr_data = 128'h99;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_ack) n_ack++;
    end
    chk("mid_wr_acks", n_ack, 5);
    wr_req = 1'b0; cmd_busy = 1'b0;
    step();
    chk("mid_cv_before", cmd_valid, 1);
    #2 rst_133M = 1'b1;
    #1;
    chk("mid_cv_async", cmd_valid, 0);
    chk("mid_busy", busy, 0);
    step();
    rst_133M = 1'b0;
    n_cv = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cmd_valid) n_cv++;
    end
    chk("mid_fifo_empty", n_cv, 0);
    rd_req = 3'b001;
    step(); chk("post_rst_ack", rd_ack, 3'b001);
    rd_req = '0;
    step(); step();
    chk("post_rst_cv", cmd_valid, 1);
    chk("post_rst_cmd", cmd, 4'b0011);
    chk("post_rst_addr", ddr_address, 25'h0000A00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
